// File: rtl/difftest_trigger_pkg.sv
// rtl/difftest_trigger_pkg.sv - shared types for the trigger-CSR difftest collector
package difftest_trigger_pkg;

  localparam int SNAP_W = 200;

  typedef struct packed {
    logic [63:0] tselect;
    logic [63:0] tdata1;
    logic [63:0] tinfo;
    logic [7:0]  coreid;
  } trig_csr_snap_t;

  typedef enum logic {S_INIT, S_RUN} coll_state_e;

endpackage

// File: rtl/difftest_sync_fifo.sv
// rtl/difftest_sync_fifo.sv - pointer-based synchronous FIFO; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module difftest_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/difftest_trigger_csr_collector.sv
// rtl/difftest_trigger_csr_collector.sv - samples trigger CSRs at commit and forwards a
// snapshot to the DPI sink only on change, forced resync or periodic resync.
module difftest_trigger_csr_collector
  import difftest_trigger_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int RESYNC_PERIOD = 1024,
  parameter int DROP_CNT_W    = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  io_valid,
  input  logic                  io_force,
  input  logic [63:0]           io_tselect,
  input  logic [63:0]           io_tdata1,
  input  logic [63:0]           io_tinfo,
  input  logic [7:0]            io_coreid,
  input  logic                  io_out_ready,
  output logic                  enable,
  output logic [63:0]           out_tselect,
  output logic [63:0]           out_tdata1,
  output logic [63:0]           out_tinfo,
  output logic [7:0]            out_coreid,
  output logic                  io_overflow,
  output logic [DROP_CNT_W-1:0] io_drop_cnt
);

  localparam int RC_W = (RESYNC_PERIOD > 1) ? $clog2(RESYNC_PERIOD) : 1;
  localparam logic [RC_W-1:0] RC_MAX = (RESYNC_PERIOD > 1) ? RC_W'(RESYNC_PERIOD - 1) : '0;

  coll_state_e     state_q, state_d;
  trig_csr_snap_t  cur_snap, last_q, last_d, out_q, out_d, fifo_rdata;
  logic [RC_W-1:0] rcnt_q, rcnt_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic            ovf_q, ovf_d, en_q, en_d;
  logic            fifo_full, fifo_empty;
  logic            pop, resync_due, push_req, push_acc, drop;

  always_comb begin
    cur_snap   = '{tselect: io_tselect, tdata1: io_tdata1, tinfo: io_tinfo, coreid: io_coreid};
    pop        = !fifo_empty && io_out_ready;
    resync_due = (RESYNC_PERIOD != 0) && (rcnt_q == RC_MAX);
    push_req   = io_valid && ((state_q == S_INIT) || io_force || resync_due || (cur_snap != last_q));
    push_acc   = push_req && (!fifo_full || pop);
    drop       = push_req && !push_acc;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    rcnt_d  = rcnt_q;
    drop_d  = drop_q;
    ovf_d   = ovf_q;
    if (push_acc) begin
      state_d = S_RUN;
      last_d  = cur_snap;
      rcnt_d  = '0;
    end else if (io_valid && (RESYNC_PERIOD > 1) && (rcnt_q != RC_MAX)) begin
      rcnt_d = rcnt_q + RC_W'(1);
    end
    // a dropped snapshot leaves last_q stale so the change is re-detected next time
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = (drop_q == '1) ? drop_q : drop_q + DROP_CNT_W'(1);
    end
    en_d  = pop;
    out_d = pop ? fifo_rdata : out_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      last_q  <= '0;
      rcnt_q  <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
      en_q    <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      rcnt_q  <= rcnt_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      en_q    <= en_d;
      out_q   <= out_d;
    end
  end

  difftest_sync_fifo #(
    .WIDTH(SNAP_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock  (clock),
    .reset_n(reset_n),
    .push   (push_acc),
    .wdata  (cur_snap),
    .pop    (pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign enable      = en_q;
  assign out_tselect = out_q.tselect;
  assign out_tdata1  = out_q.tdata1;
  assign out_tinfo   = out_q.tinfo;
  assign out_coreid  = out_q.coreid;
  assign io_overflow = ovf_q;
  assign io_drop_cnt = drop_q;

endmodule

// File: tb/tb_difftest_trigger_csr_collector.sv
// tb/tb_difftest_trigger_csr_collector.sv - directed vector bench for the collector
module tb_difftest_trigger_csr_collector;

  localparam logic [63:0] TD_A = 64'h2800_0000_0000_0000;
  localparam logic [63:0] TD_B = 64'h2800_0000_0000_0044;
  localparam logic [63:0] TD_C = 64'h2800_0000_0000_0099;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        io_valid = 1'b0, io_force = 1'b0, io_out_ready = 1'b1;
  logic [63:0] io_tselect = '0, io_tdata1 = '0, io_tinfo = 64'd4;
  logic [7:0]  io_coreid = '0;

  logic        a_en, b_en, a_ovf, b_ovf;
  logic [63:0] a_tsel, a_td1, a_tinfo, b_tsel, b_td1, b_tinfo;
  logic [7:0]  a_cid, b_cid;
  logic [15:0] a_drop, b_drop;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  difftest_trigger_csr_collector #(.FIFO_DEPTH(4), .RESYNC_PERIOD(1024), .DROP_CNT_W(16)) dut_a (
    .clock(clock), .reset_n(reset_n), .io_valid(io_valid), .io_force(io_force),
    .io_tselect(io_tselect), .io_tdata1(io_tdata1), .io_tinfo(io_tinfo), .io_coreid(io_coreid),
    .io_out_ready(io_out_ready), .enable(a_en), .out_tselect(a_tsel), .out_tdata1(a_td1),
    .out_tinfo(a_tinfo), .out_coreid(a_cid), .io_overflow(a_ovf), .io_drop_cnt(a_drop));

  difftest_trigger_csr_collector #(.FIFO_DEPTH(4), .RESYNC_PERIOD(8), .DROP_CNT_W(16)) dut_b (
    .clock(clock), .reset_n(reset_n), .io_valid(io_valid), .io_force(io_force),
    .io_tselect(io_tselect), .io_tdata1(io_tdata1), .io_tinfo(io_tinfo), .io_coreid(io_coreid),
    .io_out_ready(io_out_ready), .enable(b_en), .out_tselect(b_tsel), .out_tdata1(b_td1),
    .out_tinfo(b_tinfo), .out_coreid(b_cid), .io_overflow(b_ovf), .io_drop_cnt(b_drop));

  typedef struct {
    logic        valid;
    logic        frc;
    logic [63:0] tdata1;
    logic        exp_en;
    logic [63:0] exp_td1;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    io_valid     = 1'b0;
    io_force     = 1'b0;
    io_out_ready = 1'b1;
    reset_n      = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic expect_out(input string name, input logic [63:0] td1);
    chk({name, "_en"}, a_en, 1);
    chk({name, "_td1"}, a_td1, td1);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, TD_A, 1'b0, 64'h0};
    tbl[1] = '{1'b1, 1'b0, TD_A, 1'b1, TD_A};
    for (int i = 2; i <= 10; i++) tbl[i] = '{1'b1, 1'b0, TD_A, 1'b0, 64'h0};
    tbl[11] = '{1'b1, 1'b0, TD_B, 1'b0, 64'h0};
    tbl[12] = '{1'b1, 1'b0, TD_B, 1'b1, TD_B};
    tbl[13] = '{1'b0, 1'b1, TD_B, 1'b0, 64'h0};
    tbl[14] = '{1'b0, 1'b0, TD_C, 1'b0, 64'h0};
    tbl[15] = '{1'b0, 1'b0, TD_B, 1'b0, 64'h0};
    tbl[16] = '{1'b0, 1'b0, TD_B, 1'b0, 64'h0};

    do_reset();
    chk("reset_en", a_en, 0);
    chk("reset_ovf", a_ovf, 0);
    chk("reset_drop", a_drop, 0);
    chk("reset_td1", a_td1, 0);
    chk("reset_tinfo", a_tinfo, 0);

    // first push, suppression of identical samples, change detection, io_valid gating
    for (int i = 0; i < 17; i++) begin
      io_valid  = tbl[i].valid;
      io_force  = tbl[i].frc;
      io_tdata1 = tbl[i].tdata1;
      tick();
      chk($sformatf("vec%0d_en", i), a_en, tbl[i].exp_en);
      if (tbl[i].exp_en) begin
        chk($sformatf("vec%0d_td1", i), a_td1, tbl[i].exp_td1);
        chk($sformatf("vec%0d_tsel", i), a_tsel, 0);
        chk($sformatf("vec%0d_tinfo", i), a_tinfo, 4);
        chk($sformatf("vec%0d_cid", i), a_cid, 0);
      end
    end

    // periodic resync on the RESYNC_PERIOD=8 instance, with a force mid-period
    do_reset();
    io_tdata1 = TD_A;
    for (int i = 0; i <= 40; i++) begin
      io_valid = 1'b1;
      io_force = (i == 28);
      tick();
      chk($sformatf("resync%0d_en", i), b_en,
          (i == 1 || i == 9 || i == 17 || i == 25 || i == 29 || i == 37));
    end
    io_valid = 1'b0;
    io_force = 1'b0;
    chk("resync_ovf", b_ovf, 0);

    // overflow with ready low, drain in order, re-push of the dropped change
    do_reset();
    io_out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      io_valid  = 1'b1;
      io_tdata1 = 64'h1000 + 64'(k);
      tick();
      chk($sformatf("ovf_push%0d_en", k), a_en, 0);
    end
    chk("ovf_flag", a_ovf, 1);
    chk("ovf_drop_cnt", a_drop, 2);
    io_valid     = 1'b0;
    io_out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      expect_out($sformatf("drain%0d", j), 64'h1000 + 64'(j));
    end
    tick();
    chk("drain_done_en", a_en, 0);
    io_valid  = 1'b1;
    io_tdata1 = 64'h1004;
    tick();
    io_valid = 1'b0;
    chk("repush_lat_en", a_en, 0);
    tick();
    expect_out("repush", 64'h1004);
    chk("repush_drop_cnt", a_drop, 2);

    // full FIFO with simultaneous pop accepts the new push
    do_reset();
    io_out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      io_valid  = 1'b1;
      io_tdata1 = 64'h2000 + 64'(k);
      tick();
    end
    io_out_ready = 1'b1;
    io_tdata1    = 64'h2FFF;
    tick();
    io_valid = 1'b0;
    expect_out("fullpop0", 64'h2000);
    for (int j = 1; j < 4; j++) begin
      tick();
      expect_out($sformatf("fullpop%0d", j), 64'h2000 + 64'(j));
    end
    tick();
    expect_out("fullpop_new", 64'h2FFF);
    tick();
    chk("fullpop_done_en", a_en, 0);
    chk("fullpop_drop_cnt", a_drop, 0);
    chk("fullpop_ovf", a_ovf, 0);

    // reset while entries are queued
    do_reset();
    io_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      io_valid  = 1'b1;
      io_tdata1 = 64'h3000 + 64'(k);
      tick();
    end
    io_valid     = 1'b0;
    io_out_ready = 1'b1;
    tick();
    expect_out("prereset", 64'h3000);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_en", a_en, 0);
    tick();
    reset_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk($sformatf("stale%0d_en", j), a_en, 0);
    end
    io_valid  = 1'b1;
    io_tdata1 = 64'h3002;
    tick();
    io_valid = 1'b0;
    tick();
    expect_out("reinit", 64'h3002);
    tick();
    chk("reinit_done_en", a_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
